// File: rtl/iic_pad_ctrl.sv
// I2C pad controller: synchronised glitch-filtered inputs, pad drive,
// SDA-stuck detection and a per-channel bus-clear sequencer.
module iic_pad_ctrl #(
    parameter int N_CH          = 1,
    parameter int FILT_LEN      = 3,
    parameter int SCL_PUSH_PULL = 1,
    parameter int STUCK_CYCLES  = 1000,
    parameter int CLR_HALF      = 250
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [N_CH-1:0] iic_scl_i,
    input  logic [N_CH-1:0] iic_scl_o,
    input  logic [N_CH-1:0] iic_scl_t,
    output logic [N_CH-1:0] iic_sda_i,
    input  logic [N_CH-1:0] iic_sda_o,
    input  logic [N_CH-1:0] iic_sda_t,
    input  logic [N_CH-1:0] clr_req,
    output logic [N_CH-1:0] clr_busy,
    output logic [N_CH-1:0] clr_done,
    output logic [N_CH-1:0] clr_ok,
    output logic [N_CH-1:0] stuck,
    inout  wire  [N_CH-1:0] SCL,
    inout  wire  [N_CH-1:0] SDA
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam int HW = $clog2(CLR_HALF + 1);
    localparam logic PP = (SCL_PUSH_PULL != 0);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        STOP_LO,
        STOP_HI,
        DONE
    } state_t;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]    scl_sync;
        logic [1:0]    sda_sync;
        logic          scl_f;
        logic          sda_f;
        logic          sda_f_nx;
        logic [FW-1:0] scl_fc;
        logic [FW-1:0] sda_fc;
        logic [SW-1:0] sc;
        state_t        state;
        state_t        nstate;
        logic [HW-1:0] hc;
        logic [HW-1:0] hc_nx;
        logic [3:0]    pc;
        logic [3:0]    pc_nx;
        logic          ok;
        logic          ok_nx;
        logic          half_end;
        logic          busy;
        logic          scl_oe;
        logic          scl_out;
        logic          sda_oe;
        logic          sda_out;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                scl_sync <= 2'b11;
                sda_sync <= 2'b11;
            end else begin
                scl_sync <= {scl_sync[0], SCL[g]};
                sda_sync <= {sda_sync[0], SDA[g]};
            end
        end

        // Output flips only after FILT_LEN consecutive differing samples.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                scl_f  <= 1'b1;
                scl_fc <= '0;
            end else if (scl_sync[1] == scl_f) begin
                scl_fc <= '0;
            end else if (scl_fc == FW'(FILT_LEN - 1)) begin
                scl_f  <= scl_sync[1];
                scl_fc <= '0;
            end else begin
                scl_fc <= scl_fc + 1'b1;
            end
        end

        assign sda_f_nx = (sda_sync[1] != sda_f &&
                           sda_fc == FW'(FILT_LEN - 1)) ?
                          sda_sync[1] : sda_f;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sda_f  <= 1'b1;
                sda_fc <= '0;
            end else if (sda_sync[1] == sda_f) begin
                sda_fc <= '0;
            end else if (sda_fc == FW'(FILT_LEN - 1)) begin
                sda_f  <= sda_sync[1];
                sda_fc <= '0;
            end else begin
                sda_fc <= sda_fc + 1'b1;
            end
        end

        // Counts against the filter's next value so stuck tracks iic_sda_i.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sc <= '0;
            end else if (!sda_f_nx && iic_sda_t[g] && !busy) begin
                if (sc != SW'(STUCK_CYCLES)) begin
                    sc <= sc + 1'b1;
                end
            end else begin
                sc <= '0;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state <= IDLE;
                hc    <= '0;
                pc    <= '0;
                ok    <= 1'b0;
            end else begin
                state <= nstate;
                hc    <= hc_nx;
                pc    <= pc_nx;
                ok    <= ok_nx;
            end
        end

        assign half_end = (hc == HW'(CLR_HALF - 1));

        always_comb begin
            nstate  = state;
            hc_nx   = hc;
            pc_nx   = pc;
            ok_nx   = ok;
            busy    = 1'b1;
            scl_oe  = PP;
            scl_out = 1'b1;
            sda_oe  = 1'b0;
            sda_out = 1'b0;
            unique case (state)
                IDLE: begin
                    busy    = 1'b0;
                    sda_oe  = ~iic_sda_t[g];
                    sda_out = iic_sda_o[g];
                    if (PP) begin
                        scl_out = iic_scl_o[g] | iic_scl_t[g];
                    end else begin
                        scl_oe  = ~iic_scl_t[g] & ~iic_scl_o[g];
                        scl_out = 1'b0;
                    end
                    if (clr_req[g]) begin
                        nstate = LOW;
                        hc_nx  = '0;
                        pc_nx  = '0;
                    end
                end
                LOW: begin
                    scl_oe  = 1'b1;
                    scl_out = 1'b0;
                    hc_nx   = half_end ? '0 : hc + 1'b1;
                    if (half_end) nstate = HIGH;
                end
                HIGH: begin
                    hc_nx = half_end ? '0 : hc + 1'b1;
                    if (half_end) begin
                        pc_nx = pc + 4'd1;
                        if (sda_f) begin
                            nstate = STOP_LO;
                        end else if (pc_nx == 4'd9) begin
                            nstate = DONE;
                            ok_nx  = 1'b0;
                        end else begin
                            nstate = LOW;
                        end
                    end
                end
                STOP_LO: begin
                    // SDA falls one cycle after SCL so no START is formed.
                    scl_oe  = 1'b1;
                    scl_out = 1'b0;
                    sda_oe  = (hc != '0);
                    hc_nx   = half_end ? '0 : hc + 1'b1;
                    if (half_end) nstate = STOP_HI;
                end
                STOP_HI: begin
                    sda_oe = 1'b1;
                    hc_nx  = half_end ? '0 : hc + 1'b1;
                    if (half_end) begin
                        nstate = DONE;
                        ok_nx  = 1'b1;
                    end
                end
                DONE: begin
                    busy   = 1'b0;
                    nstate = IDLE;
                end
                default: begin
                    busy   = 1'b0;
                    nstate = IDLE;
                end
            endcase
        end

        assign SCL[g]       = scl_oe ? scl_out : 1'bz;
        assign SDA[g]       = sda_oe ? sda_out : 1'bz;
        assign iic_scl_i[g] = scl_f;
        assign iic_sda_i[g] = sda_f;
        assign clr_busy[g]  = busy;
        assign clr_done[g]  = (state == DONE);
        assign clr_ok[g]    = ok;
        assign stuck[g]     = (sc == SW'(STUCK_CYCLES));
    end

endmodule
